// File: rtl/bizhang_fsm.sv
// Obstacle-avoidance controller: synchronises and debounces active-low sensors,
// runs a timed avoidance FSM and drives H-bridge direction pins with PWM-gated enables.
module bizhang_fsm #(
  parameter int N_SENS   = 4,
  parameter int DEB_CYC  = 1000,
  parameter int BACK_CYC = 50000,
  parameter int TURN_CYC = 30000,
  parameter int PWM_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ENE,
  input  logic [N_SENS-1:0] DIN,
  input  logic [PWM_W-1:0]  SPEED,
  output logic              zuo1,
  output logic              zuo2,
  output logic              you1,
  output logic              you2,
  output logic              en1,
  output logic              en2,
  output logic [2:0]        state
);

  localparam int HALF = N_SENS / 2;
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int TMAX = (BACK_CYC > TURN_CYC) ? BACK_CYC : TURN_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [DW-1:0]    DEB_ONE  = DW'(1);
  localparam logic [TW-1:0]    BACK_LD  = TW'(BACK_CYC - 1);
  localparam logic [TW-1:0]    TURN_LD  = TW'(TURN_CYC - 1);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    TURN_L = 3'd2,
    TURN_R = 3'd3,
    BACK   = 3'd4,
    MAN_L  = 3'd5,
    MAN_R  = 3'd6,
    STOP   = 3'd7
  } state_t;

  logic [N_SENS-1:0] sync1_reg, sync2_reg, d_reg;
  logic [DW-1:0]     deb_cnt_reg;
  logic [PWM_W-1:0]  pwm_cnt_reg, pwm_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic              side_reg, side_next;   // 1 = pivot left after reversing
  state_t            st_reg, st_next, dec;
  logic              l_obs, r_obs, all_obs;
  logic              l_fwd, l_rev, r_fwd, r_rev, pwm_on;

  function automatic int count_zeros(input logic [HALF-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < HALF; i++) begin
      if (!v[i]) n++;
    end
    return n;
  endfunction

  // Input path: 2-FF synchroniser, then accept a new vector only after it
  // has differed from the current one for DEB_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      d_reg       <= '0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg <= DIN;
      sync2_reg <= sync1_reg;
      if (sync2_reg != d_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          d_reg       <= sync2_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_reg <= '0;
    else     pwm_cnt_reg <= pwm_next;
  end

  assign pwm_next = pwm_cnt_reg + PWM_ONE;
  assign pwm_on   = (pwm_next < SPEED);

  assign l_obs   = ~&d_reg[N_SENS-1:HALF];
  assign r_obs   = ~&d_reg[HALF-1:0];
  assign all_obs = (d_reg == '0);

  always_comb begin
    dec = BACK;
    if (all_obs)              dec = STOP;
    else if (!l_obs && !r_obs) dec = FWD;
    else if (l_obs && !r_obs)  dec = TURN_R;
    else if (!l_obs && r_obs)  dec = TURN_L;
  end

  always_comb begin
    st_next    = st_reg;
    timer_next = timer_reg;
    side_next  = side_reg;
    if (ENE) begin
      st_next    = IDLE;
      timer_next = '0;
    end else begin
      unique case (st_reg)
        BACK: begin
          if (timer_reg == '0) begin
            st_next    = side_reg ? MAN_L : MAN_R;
            timer_next = TURN_LD;
          end else begin
            timer_next = timer_reg - TMR_ONE;
          end
        end
        MAN_L, MAN_R: begin
          if (timer_reg == '0) st_next = dec;
          else                 timer_next = timer_reg - TMR_ONE;
        end
        default: st_next = dec;
      endcase
      // Fresh maneuver: pick the pivot side away from the denser obstacle group.
      if (st_next == BACK && st_reg != BACK) begin
        timer_next = BACK_LD;
        side_next  = (count_zeros(d_reg[N_SENS-1:HALF]) < count_zeros(d_reg[HALF-1:0]));
      end
    end
  end

  always_comb begin
    l_fwd = 1'b0;
    l_rev = 1'b0;
    r_fwd = 1'b0;
    r_rev = 1'b0;
    unique case (st_next)
      FWD: begin
        l_fwd = 1'b1;
        r_fwd = 1'b1;
      end
      TURN_L, MAN_L: r_fwd = 1'b1;
      TURN_R, MAN_R: l_fwd = 1'b1;
      BACK: begin
        l_rev = 1'b1;
        r_rev = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg    <= IDLE;
      timer_reg <= '0;
      side_reg  <= 1'b0;
      zuo1      <= 1'b0;
      zuo2      <= 1'b0;
      you1      <= 1'b0;
      you2      <= 1'b0;
      en1       <= 1'b0;
      en2       <= 1'b0;
    end else begin
      st_reg    <= st_next;
      timer_reg <= timer_next;
      side_reg  <= side_next;
      zuo1      <= l_fwd;
      zuo2      <= l_rev;
      you1      <= r_fwd;
      you2      <= r_rev;
      en1       <= (l_fwd | l_rev) & pwm_on;
      en2       <= (r_fwd | r_rev) & pwm_on;
    end
  end

  assign state = st_reg;

endmodule

// File: tb/tb_bizhang_fsm.sv
// Scoreboard bench for bizhang_fsm: stimulus queues expected state transitions
// (state, direction pins, edge number); a negedge monitor checks each one.
module tb_bizhang_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       ENE;
  logic [3:0] DIN;
  logic [3:0] SPEED;
  logic       zuo1, zuo2, you1, you2, en1, en2;
  logic [2:0] state;

  typedef struct {
    logic [2:0] st;
    logic [3:0] dir;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [2:0] prev_state = 3'd0;

  bizhang_fsm #(
    .N_SENS(4), .DEB_CYC(4), .BACK_CYC(10), .TURN_CYC(6), .PWM_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ENE(ENE), .DIN(DIN), .SPEED(SPEED),
    .zuo1(zuo1), .zuo2(zuo2), .you1(you1), .you2(you2),
    .en1(en1), .en2(en2), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every state change must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && state != prev_state) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_transition: state %0d at edge %0d, none expected", state, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (state != e.st || cyc != e.cyc || {zuo1, zuo2, you1, you2} != e.dir) begin
          n_err++;
          $display("FAIL transition: got state %0d dir %b edge %0d, expected state %0d dir %b edge %0d",
                   state, {zuo1, zuo2, you1, you2}, cyc, e.st, e.dir, e.cyc);
        end else begin
          $display("ok transition: state %0d dir %b edge %0d", state, {zuo1, zuo2, you1, you2}, cyc);
        end
      end
    end
    prev_state = state;
  end

  task automatic push(input logic [2:0] st, input logic [3:0] dir, input int at);
    exp_t e;
    e.st  = st;
    e.dir = dir;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic measure(input int n, output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    repeat (n) begin
      @(negedge clk);
      c1 += int'(en1);
      c2 += int'(en2);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end else begin
      $display("ok %s: %0d", name, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int c, a1, a2;
    rst   = 1'b1;
    ENE   = 1'b0;
    DIN   = 4'b1111;
    SPEED = 4'd15;
    repeat (3) @(negedge clk);
    check_int("reset_outputs", int'({state, zuo1, zuo2, you1, you2, en1, en2}), 0);

    // Release reset: STOP immediately (d resets to all obstacles), FWD once debounced.
    rst = 1'b0;
    c = cyc;
    push(3'd7, 4'b0000, c + 1);
    push(3'd1, 4'b1010, c + 7);
    wait_to(c + 8);
    measure(16, a1, a2);
    check_int("fwd_en1_duty15", a1, 15);
    check_int("fwd_en2_duty15", a2, 15);

    // Three-cycle glitch is rejected: no transition queued.
    DIN = 4'b1110;
    repeat (3) @(negedge clk);
    DIN = 4'b1111;
    repeat (10) @(negedge clk);

    // Right-group obstacle -> pivot left (right motor forward only).
    DIN = 4'b1110;
    c = cyc;
    push(3'd2, 4'b0010, c + 7);
    wait_to(c + 9);
    measure(8, a1, a2);
    check_int("turn_l_en1_off", a1, 0);

    // Left-group obstacle -> pivot right (left motor forward only).
    DIN = 4'b0111;
    c = cyc;
    push(3'd3, 4'b1000, c + 7);
    wait_to(c + 9);
    measure(8, a1, a2);
    check_int("turn_r_en2_off", a2, 0);

    // Both groups blocked, left has fewer zeros -> BACK, MAN_L, then decision.
    DIN = 4'b1000;
    c = cyc;
    push(3'd4, 4'b0101, c + 7);
    push(3'd5, 4'b0010, c + 17);
    push(3'd1, 4'b1010, c + 23);
    wait_to(c + 8);
    DIN = 4'b0101;
    wait_to(c + 9);
    DIN = 4'b1111;
    wait_to(c + 26);

    // Disable during BACK aborts to IDLE; re-enable with all obstacles -> STOP.
    DIN = 4'b1000;
    c = cyc;
    push(3'd4, 4'b0101, c + 7);
    wait_to(c + 8);
    DIN = 4'b0000;
    wait_to(c + 9);
    ENE = 1'b1;
    push(3'd0, 4'b0000, c + 10);
    wait_to(c + 11);
    measure(4, a1, a2);
    check_int("idle_en_off", a1 + a2, 0);
    wait_to(c + 16);
    ENE = 1'b0;
    push(3'd7, 4'b0000, c + 17);
    wait_to(c + 18);

    // Back to FWD, then PWM duty checks.
    DIN = 4'b1111;
    c = cyc;
    push(3'd1, 4'b1010, c + 7);
    wait_to(c + 8);
    SPEED = 4'd0;
    repeat (2) @(negedge clk);
    measure(32, a1, a2);
    check_int("speed0_en1", a1, 0);
    check_int("speed0_en2", a2, 0);
    check_int("speed0_dir", int'({zuo1, zuo2, you1, you2}), 10);
    SPEED = 4'd8;
    repeat (2) @(negedge clk);
    measure(16, a1, a2);
    check_int("speed8_en1", a1, 8);
    check_int("speed8_en2", a2, 8);

    repeat (5) @(negedge clk);
    check_int("pending_transitions", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
